// File: rtl/wb_pipe_stage.sv
// Write-back stage with built-in MEM/WB register.
// Holds one retiring instruction, waits for load data if needed, and commits a single
// register-file write per entry. The commit port also serves as the forwarding source.
// Optional feature: define WB_LD_TIMEOUT_EN to bound the load wait to LD_TIMEOUT cycles.
module wb_pipe_stage #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REG_AW     = 3,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned LD_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inValid,
   output logic              inReady,
   input  logic [DATA_W-1:0] incPC,
   input  logic [DATA_W-1:0] aluResult,
   input  logic [DATA_W-1:0] immExt,
   input  logic [DATA_W-1:0] aluControl,
   input  logic [2:0]        writeBackOp,
   input  logic              regWrite,
   input  logic [REG_AW-1:0] writeReg,
   input  logic              dReady,
   input  logic [DATA_W-1:0] dReadData,
   input  logic              flush,
   output logic              rfWriteEn,
   output logic [REG_AW-1:0] rfWriteReg,
   output logic [DATA_W-1:0] rfWriteData,
   output logic              err,
   output logic [CNT_W-1:0]  retireCnt,
   output logic              ldTimeout
);

   typedef enum logic [1:0] {StEmpty, StWaitLd, StHold} state_e;

   localparam logic [2:0] OpPc   = 3'd0;
   localparam logic [2:0] OpLoad = 3'd1;
   localparam logic [2:0] OpAlu  = 3'd2;
   localparam logic [2:0] OpImm  = 3'd3;
   localparam logic [2:0] OpCtl  = 3'd4;

   state_e            state_q, state_d;
   logic [2:0]        op_q;
   logic              reg_write_q;
   logic [REG_AW-1:0] write_reg_q;
   logic [DATA_W-1:0] inc_pc_q;
   logic [DATA_W-1:0] alu_result_q;
   logic [DATA_W-1:0] imm_ext_q;
   logic [DATA_W-1:0] alu_control_q;
   logic [DATA_W-1:0] ld_data_q;
   logic [CNT_W-1:0]  retire_cnt_q;

   logic              accept;
   logic              in_hold;
   logic              commit;
   logic              ld_done;
   logic              ld_to_hit;
   logic              to_err;
   logic              illegal_op;
   logic [DATA_W-1:0] wb_data;

   // Handshake: a waiting load blocks the stage; HOLD can accept because it retires now.
   assign inReady = ~flush & (state_q != StWaitLd);
   assign accept  = inValid & inReady;
   assign in_hold = (state_q == StHold);
   // A flushed HOLD entry is dropped, not retired.
   assign commit  = in_hold & ~flush;
   assign ld_done = (state_q == StWaitLd) & dReady;

`ifdef WB_LD_TIMEOUT_EN
   localparam int unsigned ToW = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;

   logic [ToW-1:0] to_cnt_q;
   logic           to_flag_q;
   logic           ld_timeout_q;

   // Last permitted wait cycle with no data: give up and retire the load as an error.
   assign ld_to_hit = (state_q == StWaitLd) & ~dReady & (32'(to_cnt_q) >= LD_TIMEOUT - 1);

   // Wait-cycle counter, per-entry timeout mark and sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q     <= '0;
         to_flag_q    <= 1'b0;
         ld_timeout_q <= 1'b0;
      end else begin
         if (accept) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
         end else if ((state_q == StWaitLd) && !ld_to_hit) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
         if (ld_to_hit && !flush) begin
            to_flag_q    <= 1'b1;
            ld_timeout_q <= 1'b1;
         end
      end
   end

   assign to_err    = to_flag_q;
   assign ldTimeout = ld_timeout_q;
`else
   assign ld_to_hit = 1'b0;
   assign to_err    = 1'b0;
   assign ldTimeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: flush overrides everything and empties the stage.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty, StHold: begin
            if (accept) begin
               state_d = (writeBackOp == OpLoad) ? StWaitLd : StHold;
            end else begin
               state_d = StEmpty;
            end
         end
         StWaitLd: begin
            if (dReady || ld_to_hit) begin
               state_d = StHold;
            end
         end
         default: state_d = StEmpty;
      endcase
      if (flush) begin
         state_d = StEmpty;
      end
   end

   // Pipeline register: capture every field on accept; load data lands while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q          <= '0;
         reg_write_q   <= 1'b0;
         write_reg_q   <= '0;
         inc_pc_q      <= '0;
         alu_result_q  <= '0;
         imm_ext_q     <= '0;
         alu_control_q <= '0;
         ld_data_q     <= '0;
      end else if (accept) begin
         op_q          <= writeBackOp;
         reg_write_q   <= regWrite;
         write_reg_q   <= writeReg;
         inc_pc_q      <= incPC;
         alu_result_q  <= aluResult;
         imm_ext_q     <= immExt;
         alu_control_q <= aluControl;
         // Cleared so a timed-out load retires with zero data.
         ld_data_q     <= '0;
      end else if (ld_done && !flush) begin
         ld_data_q <= dReadData;
      end
   end

   // Retired-instruction counter; wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_cnt_q <= '0;
      end else if (commit) begin
         retire_cnt_q <= retire_cnt_q + 1'b1;
      end
   end

   assign retireCnt = retire_cnt_q;

   // Write-back source select from the held op.
   always_comb begin
      wb_data = '0;
      case (op_q)
         OpPc:    wb_data = inc_pc_q;
         OpLoad:  wb_data = ld_data_q;
         OpAlu:   wb_data = alu_result_q;
         OpImm:   wb_data = imm_ext_q;
         OpCtl:   wb_data = alu_control_q;
         default: wb_data = '0;
      endcase
   end

   assign illegal_op = (op_q > OpCtl);

   // Commit outputs; address and data are zero outside HOLD.
   always_comb begin
      err         = commit & (illegal_op | to_err);
      rfWriteEn   = commit & reg_write_q & ~(illegal_op | to_err);
      rfWriteReg  = '0;
      rfWriteData = '0;
      if (in_hold) begin
         rfWriteReg  = write_reg_q;
         rfWriteData = wb_data;
      end
   end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Self-checking bench for wb_pipe_stage: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_wb_pipe_stage;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned REG_AW     = 3;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned LD_TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              inValid;
   logic              inReady;
   logic [DATA_W-1:0] incPC;
   logic [DATA_W-1:0] aluResult;
   logic [DATA_W-1:0] immExt;
   logic [DATA_W-1:0] aluControl;
   logic [2:0]        writeBackOp;
   logic              regWrite;
   logic [REG_AW-1:0] writeReg;
   logic              dReady;
   logic [DATA_W-1:0] dReadData;
   logic              flush;
   logic              rfWriteEn;
   logic [REG_AW-1:0] rfWriteReg;
   logic [DATA_W-1:0] rfWriteData;
   logic              err;
   logic [CNT_W-1:0]  retireCnt;
   logic              ldTimeout;

   int checks   = 0;
   int failures = 0;

   // Model of the single held entry.
   bit                m_held;
   bit                m_wait;
   bit                m_regw;
   bit                m_to;
   bit                m_ldto;
   logic [2:0]        m_op;
   logic [REG_AW-1:0] m_wreg;
   logic [DATA_W-1:0] m_data;
   int                m_tcnt;
   logic [CNT_W-1:0]  m_retire;

   always #5 clk = ~clk;

   wb_pipe_stage #(
      .DATA_W     (DATA_W),
      .REG_AW     (REG_AW),
      .CNT_W      (CNT_W),
      .LD_TIMEOUT (LD_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inValid     (inValid),
      .inReady     (inReady),
      .incPC       (incPC),
      .aluResult   (aluResult),
      .immExt      (immExt),
      .aluControl  (aluControl),
      .writeBackOp (writeBackOp),
      .regWrite    (regWrite),
      .writeReg    (writeReg),
      .dReady      (dReady),
      .dReadData   (dReadData),
      .flush       (flush),
      .rfWriteEn   (rfWriteEn),
      .rfWriteReg  (rfWriteReg),
      .rfWriteData (rfWriteData),
      .err         (err),
      .retireCnt   (retireCnt),
      .ldTimeout   (ldTimeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] pick_value(input logic [2:0] op);
      logic [DATA_W-1:0] src [8];
      src = '{incPC, '0, aluResult, immExt, aluControl, '0, '0, '0};
      return src[op];
   endfunction

   task automatic model_reset();
      m_held   = 0;
      m_wait   = 0;
      m_regw   = 0;
      m_to     = 0;
      m_ldto   = 0;
      m_op     = '0;
      m_wreg   = '0;
      m_data   = '0;
      m_tcnt   = 0;
      m_retire = '0;
   endtask

   // Every-cycle comparison of all outputs against the model.
   task automatic compare_model();
      bit ready_entry;
      bit e_err;
      bit e_we;
      ready_entry = m_held && !m_wait;
      e_err = ready_entry && !flush && (m_op >= 3'd5 || m_to);
      e_we  = ready_entry && !flush && m_regw && !e_err;
      check("inReady", 32'(inReady), 32'(!flush && !m_wait));
      check("err", 32'(err), 32'(e_err));
      check("rfWriteEn", 32'(rfWriteEn), 32'(e_we));
      check("rfWriteReg", 32'(rfWriteReg), ready_entry ? 32'(m_wreg) : 32'd0);
      check("rfWriteData", 32'(rfWriteData), ready_entry ? 32'(m_data) : 32'd0);
      check("retireCnt", 32'(retireCnt), 32'(m_retire));
      check("ldTimeout", 32'(ldTimeout), 32'(m_ldto));
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      bit ready_entry;
      ready_entry = m_held && !m_wait;
      if (flush) begin
         m_held = 0;
         m_wait = 0;
      end else if (m_wait) begin
         if (dReady) begin
            m_data = dReadData;
            m_wait = 0;
         end else begin
            m_tcnt++;
`ifdef WB_LD_TIMEOUT_EN
            if (m_tcnt == LD_TIMEOUT) begin
               m_data = '0;
               m_to   = 1;
               m_ldto = 1;
               m_wait = 0;
            end
`endif
         end
      end else begin
         if (ready_entry) begin
            m_retire = m_retire + 1'b1;
            m_held   = 0;
         end
         if (inValid) begin
            m_held = 1;
            m_wait = (writeBackOp == 3'd1);
            m_op   = writeBackOp;
            m_regw = regWrite;
            m_wreg = writeReg;
            m_data = pick_value(writeBackOp);
            m_to   = 0;
            m_tcnt = 0;
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      if (!rst) compare_model();
   endtask

   task automatic advance();
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic idle();
      inValid     = 1'b0;
      flush       = 1'b0;
      dReady      = 1'b0;
      dReadData   = '0;
      writeBackOp = 3'd0;
      regWrite    = 1'b0;
      writeReg    = '0;
   endtask

   task automatic drive(input logic [2:0] op, input logic rw, input logic [REG_AW-1:0] wr,
                        input logic [DATA_W-1:0] alu);
      inValid     = 1'b1;
      writeBackOp = op;
      regWrite    = rw;
      writeReg    = wr;
      aluResult   = alu;
      incPC       = 16'h1111;
      immExt      = 16'h2222;
      aluControl  = 16'h3333;
   endtask

   initial begin
      rst        = 1'b1;
      incPC      = '0;
      aluResult  = '0;
      immExt     = '0;
      aluControl = '0;
      idle();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      advance();

      // ALU back-to-back.
      drive(3'd2, 1'b1, 3'd3, 16'h1234);
      sample();
      advance();
      drive(3'd2, 1'b1, 3'd5, 16'h5678);
      sample();
      check("alu1 we", 32'(rfWriteEn), 32'd1);
      check("alu1 reg", 32'(rfWriteReg), 32'd3);
      check("alu1 data", 32'(rfWriteData), 32'h1234);
      advance();
      idle();
      sample();
      check("alu2 we", 32'(rfWriteEn), 32'd1);
      check("alu2 reg", 32'(rfWriteReg), 32'd5);
      check("alu2 data", 32'(rfWriteData), 32'h5678);
      advance();
      sample();
      check("alu retire", 32'(retireCnt), 32'd2);

      // Load with three stall cycles.
      drive(3'd1, 1'b1, 3'd6, 16'h0bad);
      advance();
      idle();
      for (int i = 0; i < 3; i++) begin
         sample();
         check("ld wait ready", 32'(inReady), 32'd0);
         advance();
      end
      dReady    = 1'b1;
      dReadData = 16'hBEEF;
      sample();
      check("ld dready we", 32'(rfWriteEn), 32'd0);
      advance();
      idle();
      sample();
      check("ld we", 32'(rfWriteEn), 32'd1);
      check("ld reg", 32'(rfWriteReg), 32'd6);
      check("ld data", 32'(rfWriteData), 32'hBEEF);
      advance();
      sample();
      check("ld retire", 32'(retireCnt), 32'd3);

      // Illegal op.
      drive(3'd6, 1'b1, 3'd2, 16'h4444);
      advance();
      idle();
      sample();
      check("ill err", 32'(err), 32'd1);
      check("ill we", 32'(rfWriteEn), 32'd0);
      advance();
      sample();
      check("ill err clr", 32'(err), 32'd0);
      check("ill retire", 32'(retireCnt), 32'd4);

      // Flush while waiting for a load, then flush against inValid.
      drive(3'd1, 1'b1, 3'd4, 16'h0);
      advance();
      idle();
      flush = 1'b1;
      sample();
      check("fl ready", 32'(inReady), 32'd0);
      advance();
      flush     = 1'b0;
      dReady    = 1'b1;
      dReadData = 16'hAAAA;
      sample();
      check("fl empty ready", 32'(inReady), 32'd1);
      advance();
      idle();
      sample();
      check("fl late dready we", 32'(rfWriteEn), 32'd0);
      check("fl retire", 32'(retireCnt), 32'd4);
      advance();
      drive(3'd2, 1'b1, 3'd1, 16'h7777);
      flush = 1'b1;
      sample();
      check("fl vs valid ready", 32'(inReady), 32'd0);
      advance();
      idle();
      sample();
      check("fl vs valid we", 32'(rfWriteEn), 32'd0);
      check("fl vs valid retire", 32'(retireCnt), 32'd4);
      advance();

`ifdef WB_LD_TIMEOUT_EN
      // Load that never returns.
      drive(3'd1, 1'b1, 3'd7, 16'h0);
      advance();
      idle();
      for (int i = 0; i < 4; i++) begin
         sample();
         check("to wait ready", 32'(inReady), 32'd0);
         advance();
      end
      sample();
      check("to err", 32'(err), 32'd1);
      check("to we", 32'(rfWriteEn), 32'd0);
      check("to flag", 32'(ldTimeout), 32'd1);
      advance();
      for (int i = 0; i < 3; i++) begin
         sample();
         advance();
      end
      sample();
      check("to sticky", 32'(ldTimeout), 32'd1);
      check("to retire", 32'(retireCnt), 32'd5);
      advance();
`endif

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         inValid     = ($urandom_range(0, 3) != 0);
         writeBackOp = 3'($urandom_range(0, 9) < 3 ? 1 : $urandom_range(0, 7));
         regWrite    = ($urandom_range(0, 4) != 0);
         writeReg    = REG_AW'($urandom);
         incPC       = DATA_W'($urandom);
         aluResult   = DATA_W'($urandom);
         immExt      = DATA_W'($urandom);
         aluControl  = DATA_W'($urandom);
         dReady      = ($urandom_range(0, 2) == 0);
         dReadData   = DATA_W'($urandom);
         flush       = ($urandom_range(0, 15) == 0);
         sample();
         advance();
      end

      // Asynchronous reset mid-stream takes effect without a clock edge.
      idle();
      #2;
      rst = 1'b1;
      #1;
      check("rst inReady", 32'(inReady), 32'd1);
      check("rst we", 32'(rfWriteEn), 32'd0);
      check("rst retire", 32'(retireCnt), 32'd0);
      check("rst ldTimeout", 32'(ldTimeout), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      advance();

      for (int n = 0; n < 500; n++) begin
         inValid     = ($urandom_range(0, 1) != 0);
         writeBackOp = 3'($urandom_range(0, 7));
         regWrite    = 1'b1;
         writeReg    = REG_AW'($urandom);
         aluResult   = DATA_W'($urandom);
         dReady      = ($urandom_range(0, 1) == 0);
         dReadData   = DATA_W'($urandom);
         flush       = ($urandom_range(0, 31) == 0);
         sample();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
- Parametrised write-back stage with a built-in MEM/WB pipeline register.
- Holds one retiring instruction and selects its write-back value: PC+2, load data, ALU result, extended immediate or ALU control word.
- Waits for multi-cycle data-memory load responses, then commits one register-file write.
- Sits between the memory stage and the register file; its write port also serves as the forwarding source.

Parameters:
- DATA_W, 16, datapath width of all data inputs and the write data.
- REG_AW, 3, register-file address width.
- CNT_W, 16, width of the retired-instruction counter.
- LD_TIMEOUT, 15, maximum cycles spent in WAIT_LD. Used only with WB_LD_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- inValid  in  1  memory stage presents an instruction.
- inReady  out  1  stage accepts this cycle. Transfer occurs when inValid & inReady at the clock edge.
- incPC  in  DATA_W  PC+2.
- aluResult  in  DATA_W  ALU output.
- immExt  in  DATA_W  extended immediate.
- aluControl  in  DATA_W  ALU control word.
- writeBackOp  in  3  source select.
- regWrite  in  1  instruction writes the register file.
- writeReg  in  REG_AW  destination register.
- dReady  in  1  load data valid; sampled only in WAIT_LD.
- dReadData  in  DATA_W  load data.
- flush  in  1  discard the held entry.
- rfWriteEn  out  1  register-file write strobe.
- rfWriteReg  out  REG_AW  write address.
- rfWriteData  out  DATA_W  write data.
- err  out  1  illegal writeBackOp on the committing entry.
- retireCnt  out  CNT_W  count of committed entries.
- ldTimeout  out  1  sticky load-timeout flag; constant 0 without the feature.

Behaviour:
- Reset (asynchronous, any state):
  - state = EMPTY; all captured fields, retireCnt and ldTimeout = 0.
  - rfWriteEn = 0, err = 0, rfWriteReg = 0, rfWriteData = 0.
- States: EMPTY, WAIT_LD, HOLD.
- inReady = ~flush & (state != WAIT_LD). Accepting in HOLD is legal because the held entry commits in that same cycle, so back-to-back throughput is 1 per cycle.
- A load is an entry with writeBackOp == 1.
- On an accept edge, capture all fields:
  - load → WAIT_LD;
  - any other op → HOLD.
- No accept from HOLD → EMPTY. EMPTY with no accept stays EMPTY.
- WAIT_LD:
  - dReady = 1 at an edge → capture dReadData, go to HOLD.
  - Otherwise stay in WAIT_LD.
  - Minimum load latency: accept edge N, dReady high in the following cycle, write in cycle N+2.
- HOLD (one cycle only): this is the commit cycle.
- Write data by captured writeBackOp:
  - 0 → incPC;
  - 1 → captured load data;
  - 2 → aluResult;
  - 3 → immExt;
  - 4 → aluControl;
  - 5, 6, 7 → 0.
- Commit outputs, all combinational from held state, valid only in HOLD (rfWriteReg/rfWriteData = 0 in other states):
  - err = HOLD & (op >= 5);
  - rfWriteEn = HOLD & regWrite & ~err;
  - rfWriteReg = held writeReg, rfWriteData = selected data.
- retireCnt increments by 1 at the end of every HOLD cycle, including err and regWrite=0 entries. It wraps from 2^CNT_W−1 to 0.
- Non-load latency: accept edge N → commit during the cycle after N.
- Flush:
  - flush=1 at an edge → next state EMPTY; the held entry is dropped with no write and no retireCnt increment.
  - During a flush cycle rfWriteEn and err are forced to 0 and inReady = 0, so flush beats a simultaneous inValid.
  - dReady arriving after a flush is ignored.
- Reset mid-WAIT_LD abandons the load. A later dReady has no effect.

Optional Feature:
- Macro: WB_LD_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_LD and increments each cycle spent there.
  - If it reaches LD_TIMEOUT without dReady, the stage goes to HOLD with load data = 0, sets sticky ldTimeout = 1, and forces err = 1 for that commit, so no write occurs.
  - ldTimeout clears only on rst.
- When undefined: no counter; WAIT_LD waits indefinitely; ldTimeout tied to 0.

Test Plan:
- Reset state: rst high mid-stream → inReady=1, rfWriteEn=0, retireCnt=0 immediately, without waiting for a clock edge.
- ALU back-to-back: writeBackOp=2 with aluResult=0x1234, writeReg=3, then 0x5678 to reg 5, inValid held → rfWriteEn high two consecutive cycles with (3,0x1234) then (5,0x5678); retireCnt=2.
- Load wait: op=1 to reg 6, dReady low 3 cycles then high with dReadData=0xBEEF → inReady low during the wait; one write (6,0xBEEF) the cycle after dReady.
- Illegal op: op=6 with regWrite=1 → err=1 for one cycle, rfWriteEn=0, retireCnt increments.
- Flush in WAIT_LD: load accepted, flush pulsed, then dReady=1 → no write, state EMPTY, retireCnt unchanged; flush with inValid=1 in the same cycle → entry not accepted.
- WB_LD_TIMEOUT_EN with LD_TIMEOUT=4: load with dReady never asserted → commit after 4 wait cycles with err=1, no write, ldTimeout=1 held until rst.
